// File: rtl/pll_lock_ctrl.sv
// PLL bring-up/lock supervisor: reset pulse, lock wait, stability check, retry.
// Optional PLL_LOCK_CTRL_LOL_COUNT_EN builds the saturating loss-of-lock counter.
module pll_lock_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       relock_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic       lol_event,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lol_count
);

  localparam int TM1 = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                       RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int TMAX = (TM1 > LOCK_STABLE_CYCLES) ?
                        TM1 : LOCK_STABLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_WAIT   = 3'd2,
    S_STABLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } st_t;

  st_t           st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    rty_q, rty_d;
  logic          sync1, lock_s;
  logic          take_retry;
  logic          lol_d, pll_rst_d, ready_d, fail_d;

  // pll_locked is asynchronous; only lock_s feeds decisions
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= S_IDLE;
      tmr_q <= '0;
      rty_q <= '0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
      rty_q <= rty_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    tmr_d      = tmr_q;
    rty_d      = rty_q;
    lol_d      = 1'b0;
    take_retry = 1'b0;
    if (!enable) begin
      st_d  = S_IDLE;
      tmr_d = '0;
      rty_d = '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          st_d  = S_RESET;
          tmr_d = '0;
          rty_d = '0;
        end
        S_RESET: begin
          if (tmr_q == TW'(RST_PULSE_CYCLES - 1)) begin
            st_d  = S_WAIT;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            st_d  = S_STABLE;
            tmr_d = '0;
          end else if (tmr_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            take_retry = 1'b1;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            take_retry = 1'b1;
          end else if (tmr_q == TW'(LOCK_STABLE_CYCLES - 1)) begin
            st_d  = S_RUN;
            tmr_d = '0;
            rty_d = '0;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        S_RUN: begin
          // lock loss wins over a coincident relock request
          if (!lock_s) begin
            lol_d = 1'b1;
            st_d  = S_RESET;
            tmr_d = '0;
          end else if (relock_req) begin
            st_d  = S_RESET;
            tmr_d = '0;
          end
        end
        S_FAIL: st_d = S_FAIL;
        default: begin
          st_d  = S_IDLE;
          tmr_d = '0;
          rty_d = '0;
        end
      endcase
      if (take_retry) begin
        if (rty_q == 2'(MAX_RETRIES)) begin
          st_d = S_FAIL;
        end else begin
          rty_d = rty_q + 2'd1;
          st_d  = S_RESET;
          tmr_d = '0;
        end
      end
    end
  end

  always_comb begin
    pll_rst_d = (st_d == S_IDLE) || (st_d == S_RESET) ||
                (st_d == S_FAIL);
    ready_d   = (st_d == S_RUN);
    fail_d    = (st_d == S_FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lol_event <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      ready     <= ready_d;
      fail      <= fail_d;
      lol_event <= lol_d;
    end
  end

  assign state     = st_q;
  assign retry_cnt = rty_q;

`ifdef PLL_LOCK_CTRL_LOL_COUNT_EN
  logic [7:0] lcnt_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= 8'd0;
    end else if (lol_d && (lcnt_q != 8'hFF)) begin
      lcnt_q <= lcnt_q + 8'd1;
    end
  end

  assign lol_count = lcnt_q;
`else
  assign lol_count = 8'd0;
`endif

endmodule
